icache_resp: RTL and testbench



---
 rtl/icache_resp.sv | 160 ++++++++++++++++
 tb/tb_icache_resp.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// Direct-mapped read-only instruction cache for the fetch stage.
// It refills a whole line word by word from instruction memory on a miss.
module icache_resp #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_flag,
    input  logic [31:0] addr,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned OB = $clog2(LINE_WORDS);
    localparam int unsigned IB = $clog2(NUM_LINES);
    localparam int unsigned TW = 30 - OB - IB;
    localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic [31:2]          req_q, req_d;
    logic [OB-1:0]        cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mreq_q, mreq_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          maddr_q, maddr_d;

    logic [TW-1:0] tag_q  [NUM_LINES];
    logic [31:0]   data_q [NUM_LINES*LINE_WORDS];

    logic [OB-1:0] req_off;
    logic [IB-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [OB-1:0] cnt_nxt;
    logic          hit;
    logic          data_we;
    logic          tag_we;
    logic          unused_addr;

    assign unused_addr = ^addr[1:0];
    assign req_off     = req_q[2 +: OB];
    assign req_idx     = req_q[2+OB +: IB];
    assign req_tag     = req_q[31 -: TW];
    assign cnt_nxt     = cnt_q + 1'b1;
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign read_data = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mreq_q;
    assign mem_addr  = maddr_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        maddr_d = maddr_q;
        data_we = 1'b0;
        tag_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (flush) valid_d = '0;
                if (read_flag) begin
                    state_d = S_LOOKUP;
                    req_d   = addr[31:2];
                end
            end
            S_LOOKUP: begin
                if (flush) pend_d = 1'b1;
                if (hit) begin
                    state_d = S_RESPOND;
                    rdata_d = data_q[{req_idx, req_off}];
                end else begin
                    state_d = S_REFILL;
                    cnt_d   = '0;
                    maddr_d = {req_q[31:2+OB], {OB{1'b0}}, 2'b00};
                end
            end
            S_REFILL: begin
                if (flush) pend_d = 1'b1;
                if (mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_nxt;
                    maddr_d = {req_q[31:2+OB], cnt_nxt, 2'b00};
                    // Capture the requested word as it streams past
                    if (cnt_q == req_off) rdata_d = mem_rdata;
                    if (cnt_q == LAST) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        state_d          = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                if (pend_q || flush) begin
                    valid_d = '0;
                    pend_d  = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == S_LOOKUP) || (state_d == S_REFILL);
        done_d = (state_d == S_RESPOND);
        mreq_d = (state_d == S_REFILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mreq_q  <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mreq_q  <= mreq_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
        end
    end

    // Storage needs no reset; the valid bits gate every use
    always_ff @(posedge clk) begin
        if (data_we) data_q[{req_idx, cnt_q}] <= mem_rdata;
        if (tag_we)  tag_q[req_idx]           <= req_tag;
    end

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp with a scoreboard of expected read data.
// Memory model returns addr ^ 0xA5A5_0000 with a programmable wait count.
module tb_icache_resp;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_flag;
    logic [31:0] addr;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    icache_resp #(
        .LINE_WORDS(LW),
        .NUM_LINES (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .read_flag(read_flag),
        .addr     (addr),
        .read_data(read_data),
        .busy     (busy),
        .done     (done),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           input int waits, input bit miss,
                           input int flush_at, input bit hold,
                           input int rst_at);
        int          exp_done;
        int          nacks;
        int          wcnt;
        logic [31:0] base;
        logic [31:0] exp;
        exp_done = miss ? 2 + LW * (waits + 1) : 2;
        base     = a & ~32'(LW * 4 - 1);
        nacks    = 0;
        wcnt     = 0;
        sb_q.push_back({a[31:2], 2'b00} ^ 32'hA5A5_0000);
        addr      = a;
        read_flag = 1'b1;
        flush     = (flush_at == 0);
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) read_flag = hold;
            flush = (cyc == flush_at);
            if (cyc == rst_at) begin
                rst     = 1'b0;
                mem_ack = 1'b0;
                flush   = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 0);
                check({tag, "_rst_done"}, 32'(done), 0);
                check({tag, "_rst_req"}, 32'(mem_req), 0);
                check({tag, "_rst_addr"}, mem_addr, 0);
                check({tag, "_rst_data"}, read_data, 0);
                exp = sb_q.pop_front();
                @(negedge clk);
                rst       = 1'b1;
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                @(negedge clk);
                check({tag, "_late_busy"}, 32'(busy), 0);
                check({tag, "_late_req"}, 32'(mem_req), 0);
                check({tag, "_late_done"}, 32'(done), 0);
                mem_ack = 1'b0;
                return;
            end
            check({tag, "_busy"}, 32'(busy), 32'(cyc < exp_done));
            check({tag, "_done"}, 32'(done), 32'(cyc == exp_done));
            check({tag, "_req"}, 32'(mem_req),
                  32'(miss && cyc >= 2 && cyc < exp_done));
            if (mem_req === 1'b1) begin
                check({tag, "_maddr"}, mem_addr, base + 32'(4 * nacks));
                if (wcnt == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
                    nacks++;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (cyc == exp_done) begin
                exp = sb_q.pop_front();
                check({tag, "_rdata"}, read_data, exp);
                read_flag = 1'b0;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        flush   = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_done"}, 32'(done), 0);
        check({tag, "_acks"}, 32'(nacks), miss ? 32'(LW) : 0);
    endtask

    initial begin
        rst       = 1'b1;
        read_flag = 1'b1;
        addr      = 32'h0000_0010;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_busy", 32'(busy), 0);
            check("reset_done", 32'(done), 0);
            check("reset_req", 32'(mem_req), 0);
        end
        check("reset_rdata", read_data, 0);
        check("reset_maddr", mem_addr, 0);
        read_flag = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        do_read("cold",        32'h0000_0014, 0, 1, -1, 0, -1);
        do_read("hit",         32'h0000_0018, 0, 0, -1, 1, -1);
        do_read("evict",       32'h0000_0410, 0, 1, -1, 0, -1);
        do_read("reread",      32'h0000_0010, 0, 1, -1, 0, -1);
        do_read("hit2",        32'h0000_001C, 0, 0, -1, 0, -1);
        do_read("flush_rfl",   32'h0000_0024, 0, 1,  3, 0, -1);
        do_read("post_flush",  32'h0000_0028, 0, 1, -1, 0, -1);
        do_read("flush_idle",  32'h0000_002C, 0, 1,  0, 0, -1);
        do_read("hit3",        32'h0000_0020, 0, 0, -1, 0, -1);
        do_read("wait",        32'h0000_003C, 3, 1, -1, 0, -1);
        do_read("wait_rst",    32'h0000_0044, 3, 1, -1, 0,  6);
        do_read("after_rst",   32'h0000_0040, 0, 1, -1, 0, -1);
        do_read("after_rst2",  32'h0000_003C, 0, 1, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
